// File: rtl/graphics_controller.sv
// graphics_controller
// Graphics command engine between the command front-end and the display
// buffer / palette / display driver. Decodes op-codes and operand bytes and
// drives the pixel write port (clear and clipped rectangle fill with ready
// back-pressure), the palette write port and the frame-synchronised swap.
//
// Ports:
//   clock_in, reset_in            clock and synchronous active-high reset
//   op_code_in/op_code_valid_in   current command, valid for its duration
//   operand_in/operand_valid_in   operand byte and its strobe
//   operand_count_in              1-based index of the current operand
//   busy_out                      fill engine active
//   pixel_write_*                 frame-buffer write port (ready handshake)
//   palette_write_*               one-cycle palette commit
//   frame_sync_in                 vsync level from the display driver
//   switch_buffer_out             one-cycle buffer swap strobe
module graphics_controller #(
   parameter int DISPLAY_WIDTH  = 640,
   parameter int DISPLAY_HEIGHT = 400,
   parameter int INDEX_BITS     = 4,
   parameter int COLOR_BITS     = 10,
   parameter int ADDR_BITS      = 18
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic [7:0]            op_code_in,
   input  logic                  op_code_valid_in,
   input  logic [7:0]            operand_in,
   input  logic                  operand_valid_in,
   input  logic [31:0]           operand_count_in,
   output logic                  busy_out,
   output logic                  pixel_write_enable_out,
   output logic [ADDR_BITS-1:0]  pixel_write_address_out,
   output logic [INDEX_BITS-1:0] pixel_write_data_out,
   input  logic                  pixel_write_ready_in,
   output logic                  palette_write_enable_out,
   output logic [INDEX_BITS-1:0] palette_write_index_out,
   output logic [COLOR_BITS-1:0] palette_write_value_out,
   input  logic                  frame_sync_in,
   output logic                  switch_buffer_out
);
   localparam int NB    = (COLOR_BITS + 7) / 8;
   localparam int ACC_W = NB * 8;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DISPLAY_WIDTH * DISPLAY_HEIGHT - 1);
   localparam logic [ADDR_BITS-1:0] ROW_STEP  = ADDR_BITS'(DISPLAY_WIDTH);
   localparam logic [16:0] DW17 = 17'(DISPLAY_WIDTH);
   localparam logic [16:0] DH17 = 17'(DISPLAY_HEIGHT);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RECT} state_t;
   state_t state_q, state_d;

   logic                  busy_q, busy_d;
   logic                  pix_en_q, pix_en_d;
   logic [ADDR_BITS-1:0]  pix_addr_q, pix_addr_d;
   logic [INDEX_BITS-1:0] pix_data_q, pix_data_d;
   logic                  pal_en_q, pal_en_d;
   logic [INDEX_BITS-1:0] pal_idx_q, pal_idx_d;
   logic [COLOR_BITS-1:0] pal_val_q, pal_val_d;
   logic                  switch_q, switch_d;
   logic                  swap_pend_q, swap_pend_d;
   logic [INDEX_BITS-1:0] fill_idx_q, fill_idx_d;
   logic                  op_valid_q;
   logic                  sync_q, sync_prev_q;

   logic [7:0]            op_code_q;
   logic [63:0]           rect_acc_q, rect_acc_d;
   logic [ACC_W-1:0]      pal_acc_q, pal_acc_d;
   logic [INDEX_BITS-1:0] pal_sel_q, pal_sel_d;
   logic [16:0]           cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [16:0]           x_start_q, x_start_d, x_end_q, x_end_d, y_end_q, y_end_d;
   logic [ADDR_BITS-1:0]  row_base_q, row_base_d;

   // A command starts on the first valid cycle or when the op-code changes.
   logic new_cmd, opnd, is_pal, is_rect, is_fill, clear_go, rect_go, show, fire, xfer;
   logic x_last, y_last, rect_empty;
   logic [15:0] rx, ry, rw, rh;
   logic [16:0] x_sum, y_sum, x_end_c, y_end_c;

   assign new_cmd = op_code_valid_in && (!op_valid_q || op_code_in != op_code_q);
   assign opnd    = op_code_valid_in && operand_valid_in;
   assign is_pal  = opnd && op_code_in == 8'h11;
   assign is_rect = opnd && op_code_in == 8'h12;
   assign is_fill = opnd && op_code_in == 8'h13;
   assign show    = new_cmd && op_code_in == 8'h19;

   assign {rx, ry, rw, rh} = rect_acc_q;
   assign x_sum      = {1'b0, rx} + {1'b0, rw};
   assign y_sum      = {1'b0, ry} + {1'b0, rh};
   assign x_end_c    = (x_sum > DW17) ? DW17 : x_sum;
   assign y_end_c    = (y_sum > DH17) ? DH17 : y_sum;
   assign rect_empty = (rw == 16'd0) || (rh == 16'd0) || ({1'b0, rx} >= DW17) || ({1'b0, ry} >= DH17);

   // New fills are accepted only from IDLE; otherwise they are dropped.
   assign clear_go = new_cmd && op_code_in == 8'h10 && state_q == S_IDLE;
   assign rect_go  = is_rect && operand_count_in == 32'd9 && !rect_empty && state_q == S_IDLE;

   assign xfer   = pix_en_q && pixel_write_ready_in;
   assign x_last = (cur_x_q + 17'd1) == x_end_q;
   assign y_last = (cur_y_q + 17'd1) == y_end_q;

   // Registered rising-edge compare; edges seen while filling are lost.
   assign fire = swap_pend_q && state_q == S_IDLE && sync_q && !sync_prev_q;

   // State and control registers
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         pix_en_q    <= 1'b0;
         pix_addr_q  <= '0;
         pix_data_q  <= '0;
         pal_en_q    <= 1'b0;
         pal_idx_q   <= '0;
         pal_val_q   <= '0;
         switch_q    <= 1'b0;
         swap_pend_q <= 1'b0;
         fill_idx_q  <= '0;
         op_valid_q  <= 1'b0;
         sync_q      <= 1'b0;
         sync_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         pix_en_q    <= pix_en_d;
         pix_addr_q  <= pix_addr_d;
         pix_data_q  <= pix_data_d;
         pal_en_q    <= pal_en_d;
         pal_idx_q   <= pal_idx_d;
         pal_val_q   <= pal_val_d;
         switch_q    <= switch_d;
         swap_pend_q <= swap_pend_d;
         fill_idx_q  <= fill_idx_d;
         op_valid_q  <= op_code_valid_in;
         sync_q      <= frame_sync_in;
         sync_prev_q <= sync_q;
      end
   end

   // Datapath registers (no reset; qualified by control state)
   always_ff @(posedge clock_in) begin
      op_code_q  <= op_code_in;
      rect_acc_q <= rect_acc_d;
      pal_acc_q  <= pal_acc_d;
      pal_sel_q  <= pal_sel_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      x_start_q  <= x_start_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (clear_go)     state_d = S_CLEAR;
            else if (rect_go) state_d = S_RECT;
         end
         S_CLEAR: if (xfer && pix_addr_q == LAST_ADDR) state_d = S_IDLE;
         S_RECT:  if (xfer && x_last && y_last)        state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Fill engine outputs
   always_comb begin
      busy_d     = busy_q;
      pix_en_d   = pix_en_q;
      pix_addr_d = pix_addr_q;
      pix_data_d = pix_data_q;
      cur_x_d    = cur_x_q;
      cur_y_d    = cur_y_q;
      x_start_d  = x_start_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      row_base_d = row_base_q;
      case (state_q)
         S_IDLE: begin
            if (clear_go) begin
               busy_d     = 1'b1;
               pix_en_d   = 1'b1;
               pix_addr_d = '0;
               pix_data_d = fill_idx_q;
            end else if (rect_go) begin
               busy_d     = 1'b1;
               pix_en_d   = 1'b1;
               pix_data_d = operand_in[INDEX_BITS-1:0];
               // The only multiply, done once at start; rows then step by width.
               row_base_d = ADDR_BITS'(32'(ry) * 32'(DISPLAY_WIDTH));
               pix_addr_d = row_base_d + ADDR_BITS'(rx);
               cur_x_d    = {1'b0, rx};
               x_start_d  = {1'b0, rx};
               cur_y_d    = {1'b0, ry};
               x_end_d    = x_end_c;
               y_end_d    = y_end_c;
            end
         end
         S_CLEAR: begin
            if (xfer) begin
               if (pix_addr_q == LAST_ADDR) begin
                  busy_d   = 1'b0;
                  pix_en_d = 1'b0;
               end else begin
                  pix_addr_d = pix_addr_q + 1'b1;
               end
            end
         end
         S_RECT: begin
            if (xfer) begin
               if (x_last && y_last) begin
                  busy_d   = 1'b0;
                  pix_en_d = 1'b0;
               end else if (x_last) begin
                  cur_y_d    = cur_y_q + 17'd1;
                  cur_x_d    = x_start_q;
                  row_base_d = row_base_q + ROW_STEP;
                  pix_addr_d = row_base_d + ADDR_BITS'(x_start_q);
               end else begin
                  cur_x_d    = cur_x_q + 17'd1;
                  pix_addr_d = pix_addr_q + 1'b1;
               end
            end
         end
         default: begin
            busy_d   = 1'b0;
            pix_en_d = 1'b0;
         end
      endcase
   end

   // Operand capture, palette commit, fill register and buffer swap
   always_comb begin
      rect_acc_d  = rect_acc_q;
      pal_acc_d   = pal_acc_q;
      pal_sel_d   = pal_sel_q;
      pal_en_d    = 1'b0;
      pal_idx_d   = pal_idx_q;
      pal_val_d   = pal_val_q;
      fill_idx_d  = fill_idx_q;
      if (is_rect && operand_count_in >= 32'd1 && operand_count_in <= 32'd8)
         rect_acc_d = {rect_acc_q[55:0], operand_in};
      if (is_fill && operand_count_in == 32'd1)
         fill_idx_d = operand_in[INDEX_BITS-1:0];
      if (is_pal) begin
         if (operand_count_in == 32'd1) begin
            pal_sel_d = operand_in[INDEX_BITS-1:0];
         end else if (operand_count_in >= 32'd2 && operand_count_in <= 32'(1 + NB)) begin
            // Big-endian: earlier bytes shift toward the top.
            pal_acc_d = (pal_acc_q << 8) | ACC_W'(operand_in);
            if (operand_count_in == 32'(1 + NB)) begin
               pal_en_d  = 1'b1;
               pal_idx_d = pal_sel_q;
               pal_val_d = pal_acc_d[COLOR_BITS-1:0];
            end
         end
      end
      switch_d    = fire;
      swap_pend_d = fire ? 1'b0 : (swap_pend_q | show);
   end

   assign busy_out                 = busy_q;
   assign pixel_write_enable_out   = pix_en_q;
   assign pixel_write_address_out  = pix_addr_q;
   assign pixel_write_data_out     = pix_data_q;
   assign palette_write_enable_out = pal_en_q;
   assign palette_write_index_out  = pal_idx_q;
   assign palette_write_value_out  = pal_val_q;
   assign switch_buffer_out        = switch_q;
endmodule
